// File: rtl/ahb_lite_master_port.sv
// AHB-Lite initiator: converts a valid/ready request stream into SINGLE AHB transfers with
// pipelined address phase, wait-state stalls, two-cycle ERROR recovery and ordered responses.
module ahb_lite_master_port #(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter bit         PIPELINE  = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_ADDR_DATA = 3'd3;
    localparam logic [2:0] ST_ERR       = 3'd4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    function automatic logic f_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lo[0] == 1'b0);
            3'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [2:0]  r_state;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [1:0]  r_htrans;
    logic [31:0] r_hwdata;
    logic [31:0] r_wdata_hold;
    logic        r_dwrite;
    logic        r_cancel;
    logic        r_ill_pend;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_resp_ok;
    logic        w_req_ready;
    logic        w_legal;
    logic        w_new_addr;
    logic        w_new_ill;
    logic [31:0] w_rdata_ok;
    logic [2:0]  w_next_state;
    logic [1:0]  w_htrans_next;
    logic        w_load_req;
    logic        w_addr_done;
    logic        w_rsp_valid_next;
    logic        w_rsp_err_next;
    logic [31:0] w_rsp_rdata_next;
    logic        w_cancel_next;
    logic        w_ill_pend_next;

    // Request handshake: an illegal request waiting for its response blocks further acceptance.
    always_comb begin
        w_resp_ok = (HRESP == 2'b00);
        w_legal   = f_legal(req_size, req_addr[1:0]);
        case (r_state)
            ST_IDLE:      w_req_ready = !r_ill_pend;
            ST_ADDR:      w_req_ready = (PIPELINE == 1'b1) && HREADY && w_resp_ok && !r_ill_pend;
            ST_ADDR_DATA: w_req_ready = HREADY && w_resp_ok && !r_ill_pend;
            default:      w_req_ready = 1'b0;
        endcase
        w_new_addr = req_valid && w_req_ready && w_legal;
        w_new_ill  = req_valid && w_req_ready && !w_legal;
        w_rdata_ok = r_dwrite ? 32'd0 : HRDATA;
    end

    // Transfer sequencing: address/data phase overlap, error recovery and response generation.
    always_comb begin
        w_next_state     = r_state;
        w_htrans_next    = r_htrans;
        w_load_req       = 1'b0;
        w_addr_done      = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = 1'b0;
        w_rsp_rdata_next = 32'd0;
        w_cancel_next    = r_cancel;
        w_ill_pend_next  = r_ill_pend;
        case (r_state)
            ST_IDLE: begin
                if (r_ill_pend) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    w_ill_pend_next  = 1'b0;
                end else if (w_new_addr) begin
                    w_load_req    = 1'b1;
                    w_htrans_next = TR_NONSEQ;
                    w_next_state  = ST_ADDR;
                end else if (w_new_ill) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    w_addr_done = 1'b1;
                    if (w_new_addr) begin
                        w_load_req    = 1'b1;
                        w_htrans_next = TR_NONSEQ;
                        w_next_state  = ST_ADDR_DATA;
                    end else begin
                        w_htrans_next   = TR_IDLE;
                        w_next_state    = ST_DATA;
                        w_ill_pend_next = r_ill_pend || w_new_ill;
                    end
                end else begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (!w_resp_ok) begin
                    if (HREADY) begin
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_next_state     = ST_IDLE;
                    end else begin
                        w_next_state = ST_ERR;
                    end
                end else if (HREADY) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = w_rdata_ok;
                    w_next_state     = ST_IDLE;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_ADDR_DATA: begin
                if (!w_resp_ok) begin
                    // Pipelined address is withdrawn and replayed once the error completes.
                    if (HREADY) begin
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_next_state     = ST_ADDR;
                    end else begin
                        w_htrans_next = TR_IDLE;
                        w_cancel_next = 1'b1;
                        w_next_state  = ST_ERR;
                    end
                end else if (HREADY) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = w_rdata_ok;
                    w_addr_done      = 1'b1;
                    if (w_new_addr) begin
                        w_load_req    = 1'b1;
                        w_htrans_next = TR_NONSEQ;
                        w_next_state  = ST_ADDR_DATA;
                    end else begin
                        w_htrans_next   = TR_IDLE;
                        w_next_state    = ST_DATA;
                        w_ill_pend_next = r_ill_pend || w_new_ill;
                    end
                end else begin
                    w_next_state = ST_ADDR_DATA;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    if (r_cancel) begin
                        w_htrans_next = TR_NONSEQ;
                        w_cancel_next = 1'b0;
                        w_next_state  = ST_ADDR;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_ERR;
                end
            end
            default: begin
                w_next_state    = ST_IDLE;
                w_htrans_next   = TR_IDLE;
                w_cancel_next   = 1'b0;
                w_ill_pend_next = 1'b0;
            end
        endcase
    end

    // State, bus and response registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_haddr      <= 32'd0;
            r_hwrite     <= 1'b0;
            r_hsize      <= 3'd0;
            r_htrans     <= TR_IDLE;
            r_hwdata     <= 32'd0;
            r_wdata_hold <= 32'd0;
            r_dwrite     <= 1'b0;
            r_cancel     <= 1'b0;
            r_ill_pend   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 32'd0;
        end else begin
            r_state     <= w_next_state;
            r_htrans    <= w_htrans_next;
            r_cancel    <= w_cancel_next;
            r_ill_pend  <= w_ill_pend_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            if (w_load_req) begin
                r_haddr      <= req_addr;
                r_hwrite     <= req_write;
                r_hsize      <= req_size;
                r_wdata_hold <= req_wdata;
            end
            if (w_addr_done) begin
                r_dwrite <= r_hwrite;
                if (r_hwrite) begin
                    r_hwdata <= r_wdata_hold;
                end
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HTRANS    = r_htrans;
    assign HWDATA    = r_hwdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Directed bench for ahb_lite_master_port: a transaction-level model (request, bus and
// response queues plus a scripted slave) checks the DUT on every negative clock edge.
module tb_ahb_lite_master_port;

    logic        HCLK, HRESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS, HRESP;
    logic [3:0]  HPROT;

    ahb_lite_master_port #(.HPROT_VAL(4'b0011), .PIPELINE(1'b1)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; int lat; } req_t;
    typedef struct { logic err; logic [31:0] rdata; int acc_cyc; int lat; } rsp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; } bus_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scripted slave configuration and current data phase
    int          slv_wait   = 0;
    logic        slv_err_en = 1'b0;
    logic [31:0] slv_err_addr = 32'd0;
    logic        dp_active = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
    logic [31:0] dp_addr = 32'd0, dp_wdata = 32'd0;
    int          dp_wait = 0, dp_err_cyc = 0;

    logic        prev_ok = 1'b0, prev_hready = 1'b1;
    logic [1:0]  prev_hresp = 2'b00, prev_htrans = 2'b00;
    logic [31:0] prev_haddr = 32'd0, prev_hwdata = 32'd0;

    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    int          err_pulses = 0, rsp_cnt = 0, run = 0, max_run = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h1234_5678;
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b0;
        if (s == 3'd1 && a[0]) return 1'b0;
        if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_req(input logic wr, input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] wd, input int lat);
        req_t q;
        q.wr = wr; q.addr = a; q.size = s; q.wdata = wd; q.lat = lat;
        req_q.push_back(q);
    endtask

    // One clock cycle: check outputs, drive the slave, offer a request, account acceptance.
    task automatic step();
        logic        hr;
        logic [1:0]  hp;
        logic [31:0] rd;
        bus_t        b;
        rsp_t        r;
        req_t        q;
        @(negedge HCLK);
        cyc++;
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
                chk("rsp_rdata", rsp_rdata, r.rdata);
                if (r.lat >= 0) chk("rsp_latency", 32'(cyc - r.acc_cyc), 32'(r.lat));
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                if (rsp_err) err_pulses++;
            end
        end
        chk("bus_const", {24'd0, HBURST, HPROT, HMASTLOCK}, {24'd0, 3'b000, 4'b0011, 1'b0});
        chk("htrans_legal", {31'd0, (HTRANS == 2'b00 || HTRANS == 2'b10)}, 32'd1);
        if (prev_ok && !prev_hready && prev_hresp == 2'b00) begin
            chk("freeze_haddr", HADDR, prev_haddr);
            chk("freeze_htrans", {30'd0, HTRANS}, {30'd0, prev_htrans});
            chk("freeze_hwdata", HWDATA, prev_hwdata);
        end
        if (HTRANS == 2'b10) run++; else run = 0;
        if (run > max_run) max_run = run;

        hr = 1'b1; hp = 2'b00; rd = 32'hDEAD_BEEF;
        if (dp_active) begin
            if (dp_err) begin
                hp = 2'b01;
                if (dp_err_cyc == 0) begin
                    hr = 1'b0;
                    dp_err_cyc = 1;
                end else begin
                    chk("err2_htrans_idle", {30'd0, HTRANS}, 32'd0);
                end
            end else if (dp_wait > 0) begin
                hr = 1'b0;
                dp_wait--;
            end else if (!dp_write) begin
                rd = slave_rd(dp_addr);
            end
            if (dp_write) chk("hwdata", HWDATA, dp_wdata);
        end
        HREADY = hr; HRESP = hp; HRDATA = rd;

        if (HTRANS == 2'b10 && hr && hp == 2'b00) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_nonseq", {30'd0, HTRANS}, 32'd0);
            end else begin
                b = bus_q.pop_front();
                chk("haddr", HADDR, b.addr);
                chk("hwrite", {31'd0, HWRITE}, {31'd0, b.wr});
                chk("hsize", {29'd0, HSIZE}, {29'd0, b.size});
                dp_active = 1'b1; dp_addr = b.addr; dp_write = b.wr; dp_wdata = b.wdata;
                dp_wait = slv_wait; dp_err = slv_err_en && (b.addr == slv_err_addr); dp_err_cyc = 0;
            end
        end else if (dp_active && hr) begin
            dp_active = 1'b0;
        end

        if (req_q.size() > 0) begin
            q = req_q[0];
            req_valid = 1'b1; req_write = q.wr; req_addr = q.addr; req_size = q.size; req_wdata = q.wdata;
        end else begin
            req_valid = 1'b0;
        end
        #1;
        if (!hr) chk("no_accept_wait", {31'd0, req_ready}, 32'd0);
        if (req_valid && req_ready) begin
            q = req_q.pop_front();
            r.acc_cyc = cyc; r.lat = q.lat;
            if (is_legal(q.addr, q.size)) begin
                b.wr = q.wr; b.addr = q.addr; b.size = q.size; b.wdata = q.wdata;
                bus_q.push_back(b);
                r.err   = slv_err_en && (q.addr == slv_err_addr);
                r.rdata = (q.wr || r.err) ? 32'd0 : slave_rd(q.addr);
            end else begin
                r.err = 1'b1; r.rdata = 32'd0;
            end
            rsp_q.push_back(r);
        end
        prev_ok = 1'b1; prev_hready = hr; prev_hresp = hp;
        prev_haddr = HADDR; prev_htrans = HTRANS; prev_hwdata = HWDATA;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0 || dp_active) && n < 60) begin
            step();
            n++;
        end
        chk(name, 32'(req_q.size() + rsp_q.size()), 32'd0);
        step();
        step();
    endtask

    task automatic clear_model();
        req_q.delete(); rsp_q.delete(); bus_q.delete();
        dp_active = 1'b0; prev_ok = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'd0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 3'd0; req_wdata = 32'd0;
        step(); step();
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        HRESETn = 1'b1;
        step();

        // 1: single read, zero wait states
        push_req(1'b0, 32'h0000_0008, 3'd2, 32'd0, 3);
        drain("t1_drain");
        chk("t1_rdata", last_rdata, 32'h1234_5678);
        chk("t1_err", {31'd0, last_err}, 32'd0);

        // 2: back-to-back writes
        max_run = 0;
        push_req(1'b1, 32'h0000_0000, 3'd2, 32'hAAAA_0001, 3);
        push_req(1'b1, 32'h0000_0004, 3'd2, 32'h5555_0002, 3);
        drain("t2_drain");
        chk("t2_nonseq_run", 32'(max_run), 32'd2);

        // 3: three wait states per data phase, second read pipelined behind
        slv_wait = 3; rsp_cnt = 0;
        push_req(1'b0, 32'h0000_0010, 3'd2, 32'd0, 6);
        push_req(1'b0, 32'h0000_0014, 3'd2, 32'd0, 9);
        drain("t3_drain");
        chk("t3_rsp_count", 32'(rsp_cnt), 32'd2);
        slv_wait = 0;

        // 4: slave ERROR on write with read pipelined behind it
        slv_err_en = 1'b1; slv_err_addr = 32'h0001_E400; err_pulses = 0;
        push_req(1'b1, 32'h0001_E400, 3'd2, 32'h1111_2222, -1);
        push_req(1'b0, 32'h0001_E800, 3'd2, 32'd0, -1);
        drain("t4_drain");
        chk("t4_err_pulses", 32'(err_pulses), 32'd1);
        chk("t4_read_rdata", last_rdata, 32'hC0DF_E800);
        chk("t4_read_err", {31'd0, last_err}, 32'd0);
        slv_err_en = 1'b0;

        // 5: illegal requests, alone and queued behind a legal read
        err_pulses = 0;
        push_req(1'b0, 32'h0000_0002, 3'd2, 32'd0, 1);
        push_req(1'b0, 32'h0000_0000, 3'd3, 32'd0, 1);
        push_req(1'b0, 32'h0000_0020, 3'd2, 32'd0, 3);
        push_req(1'b1, 32'h0000_0021, 3'd1, 32'h0BAD_0BAD, -1);
        drain("t5_drain");
        chk("t5_err_pulses", 32'(err_pulses), 32'd3);
        chk("t5_last_err", {31'd0, last_err}, 32'd1);

        // 6: reset during the data phase of a write
        slv_wait = 2; rsp_cnt = 0;
        push_req(1'b1, 32'h0000_0030, 3'd2, 32'h600D_F00D, -1);
        step(); step(); step();
        HRESETn = 1'b0;
        clear_model();
        step();
        chk("t6_htrans", {30'd0, HTRANS}, 32'd0);
        chk("t6_haddr", HADDR, 32'd0);
        chk("t6_hwdata", HWDATA, 32'd0);
        chk("t6_ctrl", {28'd0, HWRITE, HSIZE}, 32'd0);
        HRESETn = 1'b1;
        slv_wait = 0;
        step(); step(); step();
        chk("t6_no_rsp", 32'(rsp_cnt), 32'd0);
        push_req(1'b0, 32'h0000_0008, 3'd2, 32'd0, 3);
        drain("t6_drain");
        chk("t6_rdata", last_rdata, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
